// File: rtl/cdb_arbiter.sv
// CDB writeback slot arbiter: multiplier reservations shift toward the bus, and the remaining
// slots go to branch, then mem, then ALU requesters. Define CDB_ARB_RR_EN for round-robin ALUs.
module cdb_arbiter #(
  parameter int unsigned N_CDB      = 3,
  parameter int unsigned NUM_BRANCH = 1,
  parameter int unsigned NUM_MEM    = 1,
  parameter int unsigned NUM_ALU    = 3,
  parameter int unsigned NUM_MULT   = 1,
  parameter int unsigned MULT_LAT   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mispredict,
  input  logic [NUM_BRANCH-1:0]        branch_req,
  input  logic [NUM_MEM-1:0]           mem_req,
  input  logic [NUM_ALU-1:0]           alu_req,
  input  logic [NUM_MULT-1:0]          mult_issue,
  output logic [NUM_BRANCH-1:0]        branch_grants,
  output logic [NUM_MEM-1:0]           mem_grants,
  output logic [NUM_ALU-1:0]           alu_grants,
  output logic [$clog2(N_CDB+1)-1:0]   free_slots
);

  localparam int unsigned CW = $clog2(N_CDB + 1);
  localparam logic [CW-1:0] NCdbW = CW'(N_CDB);

  // res_q[k]: multiply results that will broadcast k cycles from now
  logic [CW-1:0] res_q [1:MULT_LAT-1];
  logic [CW-1:0] mult_cnt;
  logic [CW-1:0] budget;

`ifdef CDB_ARB_RR_EN
  localparam int unsigned PW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  int unsigned   last_alu;
  logic          alu_any;
`endif

  always_comb begin
    mult_cnt = '0;
    for (int i = 0; i < NUM_MULT; i++) begin
      mult_cnt = mult_cnt + CW'(mult_issue[i]);
    end
  end

  // Reset forces the full width so issue sees a clean bus while state is being cleared
  assign free_slots = reset ? NCdbW : (NCdbW - res_q[1]);

  always_comb begin
    int unsigned idx;
    branch_grants = '0;
    mem_grants    = '0;
    alu_grants    = '0;
    budget        = free_slots;
    idx           = 0;
`ifdef CDB_ARB_RR_EN
    last_alu      = 0;
    alu_any       = 1'b0;
`endif
    if (!reset && !mispredict) begin
      for (int i = 0; i < NUM_BRANCH; i++) begin
        if (branch_req[i] && budget != '0) begin
          branch_grants[i] = 1'b1;
          budget           = budget - 1'b1;
        end
      end
      for (int i = 0; i < NUM_MEM; i++) begin
        if (mem_req[i] && budget != '0) begin
          mem_grants[i] = 1'b1;
          budget        = budget - 1'b1;
        end
      end
      for (int i = 0; i < NUM_ALU; i++) begin
`ifdef CDB_ARB_RR_EN
        idx = (int'(rr_ptr_q) + i) % NUM_ALU;
`else
        idx = i;
`endif
        if (alu_req[idx] && budget != '0) begin
          alu_grants[idx] = 1'b1;
          budget          = budget - 1'b1;
`ifdef CDB_ARB_RR_EN
          last_alu        = idx;
          alu_any         = 1'b1;
`endif
        end
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  assign rr_ptr_d = alu_any ? PW'((last_alu + 1) % NUM_ALU) : rr_ptr_q;

  // Grants are already zero under mispredict, so the pointer holds without extra gating
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 1; k < MULT_LAT; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < MULT_LAT - 1; k++) begin
        res_q[k] <= res_q[k+1];
      end
      res_q[MULT_LAT-1] <= mult_cnt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus a mult-saturation sequence.
// Expected ALU grants follow the build: round-robin with CDB_ARB_RR_EN, fixed priority otherwise.
module tb_cdb_arbiter;

  logic       clock = 1'b0;
  logic       reset, mispredict;
  logic [0:0] branch_req, mem_req, mult_issue;
  logic [2:0] alu_req;
  logic [0:0] branch_grants, mem_grants;
  logic [2:0] alu_grants;
  logic [1:0] free_slots;

  int errors = 0;
  int checks = 0;

  cdb_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .mispredict   (mispredict),
    .branch_req   (branch_req),
    .mem_req      (mem_req),
    .alu_req      (alu_req),
    .mult_issue   (mult_issue),
    .branch_grants(branch_grants),
    .mem_grants   (mem_grants),
    .alu_grants   (alu_grants),
    .free_slots   (free_slots)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       mp;
    logic       br;
    logic       mm;
    logic [2:0] alu;
    logic       mult;
    logic       eb;
    logic       em;
    logic [2:0] ea_rr;
    logic [2:0] ea_fx;
    logic [1:0] ef;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mp, input logic br, input logic mm,
                       input logic [2:0] alu, input logic mult);
    @(posedge clock);
    #1;
    reset      = rst;
    mispredict = mp;
    branch_req = br;
    mem_req    = mm;
    alu_req    = alu;
    mult_issue = mult;
    @(negedge clock);
  endtask

  initial begin
    logic [2:0] ea;
    reset = 1'b1; mispredict = 1'b0; branch_req = '0; mem_req = '0; alu_req = '0;
    mult_issue = '0;

    //          rst  mp   br   mm   alu   mult eb   em   ea_rr ea_fx ef
    tbl[0]  = '{1'b1,1'b0,1'b1,1'b1,3'd7,1'b0,1'b0,1'b0,3'd0,3'd0,2'd3};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,3'd7,1'b0,1'b1,1'b1,3'd1,3'd1,2'd3};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,3'd7,1'b0,1'b1,1'b1,3'd2,3'd1,2'd3};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,3'd7,1'b0,1'b1,1'b1,3'd4,3'd1,2'd3};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b1,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd3,3'd3,2'd2};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,1'b0,1'b0,3'd1,3'd1,2'd3};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,3'd0,2'd3};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,3'd7,1'b0,1'b0,1'b0,3'd0,3'd0,2'd3};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd6,3'd3,2'd2};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0,3'd7,1'b0,1'b1,1'b0,3'd3,3'd3,2'd3};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b0,3'd7,1'b0,1'b1,1'b0,3'd5,3'd3,2'd3};
    tbl[15] = '{1'b0,1'b0,1'b1,1'b0,3'd7,1'b0,1'b1,1'b0,3'd6,3'd3,2'd3};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b1,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[17] = '{1'b1,1'b1,1'b1,1'b1,3'd7,1'b0,1'b0,1'b0,3'd0,3'd0,2'd3};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd7,3'd7,2'd3};
    tbl[19] = '{1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,1'b0,1'b0,3'd7,3'd7,2'd3};

    for (int r = 0; r < 20; r++) begin
      drive(tbl[r].rst, tbl[r].mp, tbl[r].br, tbl[r].mm, tbl[r].alu, tbl[r].mult);
`ifdef CDB_ARB_RR_EN
      ea = tbl[r].ea_rr;
`else
      ea = tbl[r].ea_fx;
`endif
      chk("branch_grants", r, int'(branch_grants), int'(tbl[r].eb));
      chk("mem_grants",    r, int'(mem_grants),    int'(tbl[r].em));
      chk("alu_grants",    r, int'(alu_grants),    int'(ea));
      chk("free_slots",    r, int'(free_slots),    int'(tbl[r].ef));
    end

    // Saturation: mult issues 8 cycles running with every requester active
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b111, (i < 8) ? 1'b1 : 1'b0);
      if (i >= 3 && i <= 10) begin
        ea = 3'b000;
      end else begin
`ifdef CDB_ARB_RR_EN
        ea = (i == 1) ? 3'b010 : (i == 2) ? 3'b100 : 3'b001;
`else
        ea = 3'b001;
`endif
      end
      chk("sat_branch", 100 + i, int'(branch_grants), 1);
      chk("sat_mem",    100 + i, int'(mem_grants),    1);
      chk("sat_alu",    100 + i, int'(alu_grants),    int'(ea));
      chk("sat_free",   100 + i, int'(free_slots),    (i >= 3 && i <= 10) ? 2 : 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
